// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with valid/ready flow control.
// An input capture rank feeds SHW shift stages; stage k shifts by 2^k when its amount bit is set.
module shift_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode
);

  logic             stall;
  logic             ready_q;
  logic             cap_valid;
  logic [WIDTH-1:0] cap_data;
  logic [SHW-1:0]   cap_amt;
  logic [1:0]       cap_mode;

  // One step of 2^k bits; ASR fill comes from the stage-entry MSB, which earlier ASR steps preserve.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] mode,
                                                  input int n);
    logic [WIDTH-1:0] fill;
    fill = ~({WIDTH{1'b1}} >> n);
    case (mode)
      2'b00:   shift_step = d << n;
      2'b01:   shift_step = d >> n;
      2'b10:   shift_step = (d >> n) | (d[WIDTH-1] ? fill : '0);
      default: shift_step = (d >> n) | (d << (WIDTH - n));
    endcase
  endfunction

  assign stall    = out_valid && !out_ready;
  assign in_ready = ready_q && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cap_amt   <= '0;
      cap_mode  <= '0;
    end else begin
      ready_q <= 1'b1;
      if (!stall) begin
        cap_valid <= in_valid && in_ready;
        cap_data  <= in_data;
        cap_amt   <= in_amt;
        cap_mode  <= in_mode;
      end
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int RW = SHW - k;

    logic [WIDTH-1:0] src_data;
    logic [RW-1:0]    src_amt;
    logic [1:0]       src_mode;
    logic             src_valid;
    logic [WIDTH-1:0] data_r;
    logic [1:0]       mode_r;
    logic             valid_r;

    if (k == 0) begin : g_src
      assign src_data  = cap_data;
      assign src_amt   = cap_amt;
      assign src_mode  = cap_mode;
      assign src_valid = cap_valid;
    end else begin : g_src
      assign src_data  = g_stage[k-1].data_r;
      assign src_amt   = g_stage[k-1].g_amt.amt_r;
      assign src_mode  = g_stage[k-1].mode_r;
      assign src_valid = g_stage[k-1].valid_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_r  <= '0;
        mode_r  <= '0;
        valid_r <= 1'b0;
      end else if (!stall) begin
        data_r  <= src_amt[0] ? shift_step(src_data, src_mode, 2 ** k) : src_data;
        mode_r  <= src_mode;
        valid_r <= src_valid;
      end
    end

    // Only the amount bits still ahead of this stage travel on.
    if (k < SHW - 1) begin : g_amt
      logic [RW-2:0] amt_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_r <= '0;
        end else if (!stall) begin
          amt_r <= src_amt[RW-1:1];
        end
      end
    end
  end

  assign out_valid = g_stage[SHW-1].valid_r;
  assign out_data  = g_stage[SHW-1].data_r;
  assign out_mode  = g_stage[SHW-1].mode_r;

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Pipelined, parametrised barrel shifter for the operator library. Accepts one operand per cycle with a run-time shift amount and mode (logical left, logical right, arithmetic right, rotate right), and produces results through a log2(WIDTH)-stage pipeline with valid/ready flow control. It replaces fixed-amount, fixed-width combinational shifts wherever a datapath needs variable shifts at full clock rate with backpressure.

## Interface
- WIDTH, default 8: operand width in bits. Must be a power of two and at least 2.
- SHW, default $clog2(WIDTH): shift-amount width and pipeline depth. Derived; never overridden.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  the input beat is presented.
- in_ready  output  1  the block accepts a beat this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- out_valid  output  1  a result is presented.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.
- out_mode  output  2  mode travelling with the result.

## Operation
- A transfer occurs on a rising edge when in_valid && in_ready. The output handshake completes when out_valid && out_ready.
- The pipeline has SHW stages. Stage k (k = 0..SHW-1) registers the data, remaining amount bits, mode, and a valid bit.
- Stage k applies a shift of 2^k when amount bit k is set; otherwise it passes the data through.
- Per-mode step of n bits:
  - LSL: shift left, zero fill.
  - LSR: shift right, zero fill.
  - ASR: shift right, filling with the operand's original MSB. The MSB of the data at stage entry is correct, because previous ASR steps preserve it.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- in_amt = 0 yields in_data unchanged in every mode.
- Amounts never exceed WIDTH-1, so no overflow case exists.
- Stall rule (global): stall = out_valid && !out_ready.
  - While stall is high, every stage register holds its value.
  - in_ready = !stall.
- Without a stall, all stages advance every cycle, including bubbles (valid = 0). Data registers of bubble stages may load don't-care values, but their valid bits are 0.
- Bubbles are not compressed. A stall freezes the whole pipe, even if earlier stages are empty.
- Inputs are ignored when in_valid = 0 or in_ready = 0. No beat is lost or duplicated.
- Reset (rst_n low, asynchronous, any time, including mid-stream):
  - All valid bits clear immediately; out_valid = 0.
  - out_data and out_mode read 0.
  - in_ready = 1 from the first edge after release.
  - In-flight beats are discarded.

## Timing
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+SHW (N+3 for WIDTH = 8), provided no stall occurs.
- Each stall cycle adds one cycle to the latency of every beat in flight.
- Throughput: one beat per cycle while out_ready stays high.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid to in_ready.
- out_data, out_mode, and out_valid are driven directly from last-stage registers. They hold stable while out_valid && !out_ready.
- Simultaneous events:
  - An input accept and an output pop can occur in the same cycle.
  - When out_ready rises on the cycle a stall clears, that pop and a new accept happen together.
- Reset values: in_ready = 0 during reset, 1 afterwards. out_valid = 0, out_data = 0, out_mode = 0.

## Test plan
- Mode sweep, WIDTH = 8, in_data = 0xB6, in_amt = 3, out_ready = 1, back-to-back modes 00/01/10/11:
  - Required results on 4 consecutive cycles: 0xB0, 0x16, 0xF6, 0xD6.
  - The first result has out_valid high after edge N+3.
- Amount edges, in_data = 0x81, all modes:
  - amt 0 returns 0x81 in every mode.
  - amt 7: LSL 0x80, LSR 0x01, ASR 0xFF, ROR 0x03.
- Backpressure: stream 0x01..0x10 with random amt and mode; toggle out_ready randomly, holding it low for 5 cycles mid-stream.
  - Results must match a reference model in order, with no drops or duplicates.
  - out_data must stay stable while stalled.
  - in_ready must equal !(out_valid && !out_ready).
- Bubbles: present in_valid every other cycle.
  - Results emerge every other cycle at latency 3.
  - out_valid must never assert for a bubble.
- Reset mid-operation: assert rst_n low asynchronously, between edges, with 3 beats in flight.
  - out_valid drops without waiting for a clock edge.
  - After release, no stale result appears.
  - The next beat (0xF0, ASR 4 → 0xFF) arrives at latency 3.
- WIDTH = 32 instance: in_data 0x8000_0001, ROR 1 → 0xC000_0000; ASR 31 → 0xFFFF_FFFF. Latency is 5 cycles.
